game_controller: RTL and testbench
==================================

// Module: game_controller
// PURPOSE
//  Pong match sequencer, downstream of the ball stage.
//  - Consumes the ball stage's p1/p2 scored flags; keeps both scores; decides serve direction.
//  - Drives ball run/re-centre control and declares a winner at WIN_SCORE.
//  - Owns the IDLE/SERVE/PLAY/POINT/OVER flow, keyed from the keyboard byte stream.
// PARAMETERS
//  START        103  key byte that starts a match ('g')
//  RESTART      98   key byte that aborts/clears to IDLE ('b')
//  WIN_SCORE    7    points needed to win; 1..(2**SCORE_W)-1
//  SERVE_DELAY  60   i_frame_tick pulses spent in SERVE before PLAY (0 allowed)
//  SCORE_W      4    score counter width
// PORTS
//  i_CLK         in   1        system clock; single clock domain
//  i_RST_N       in   1        synchronous, active-low reset
//  i_frame_tick  in   1        1-cycle pulse once per video frame
//  i_key_byte    in   8        current keyboard byte (level, sampled every cycle)
//  i_p1_scored   in   1        ball stage: P1 scored flag (level, may stay high)
//  i_p2_scored   in   1        ball stage: P2 scored flag (level, may stay high)
//  o_state       out  3        0=IDLE 1=SERVE 2=PLAY 3=POINT 4=OVER
//  o_ball_run    out  1        1 = ball may move (high only in PLAY)
//  o_ball_reset  out  1        1-cycle pulse: re-centre ball, clear its scored flags
//  o_serve_dir   out  1        0 = serve right (toward P2), 1 = serve left (toward P1)
//  o_p1_score    out  SCORE_W  P1 points
//  o_p2_score    out  SCORE_W  P2 points
//  o_winner      out  2        0 none, 1 P1, 2 P2
// BEHAVIOUR
//  - Reset (i_RST_N=0 at edge): state IDLE; all outputs 0; delay counter 0; edge regs 0.
//  - All outputs registered; every transition visible 1 cycle after the qualifying input.
//  - Score inputs are rising-edge detected (prev-value regs update every cycle, any state).
//    Edges are acted on only in PLAY; a level held high never re-scores.
//  - RESTART in any state: next state IDLE, scores/winner 0, o_ball_reset pulsed.
//    RESTART beats START and beats a same-cycle score edge.
//  - IDLE:  scores 0, run 0. START -> SERVE: counter <= SERVE_DELAY, pulse o_ball_reset, serve_dir 0.
//  - SERVE: run 0. Counter decrements on i_frame_tick.
//      Counter==0 -> PLAY on the next cycle; SERVE_DELAY=0 gives a 1-cycle SERVE.
//  - PLAY:  run 1.
//      P1 edge only -> p1_score+1, serve_dir 0.
//      P2 edge only -> p2_score+1, serve_dir 1.
//      Both edges in one cycle -> no score change, serve_dir unchanged (replay).
//      Any edge -> POINT.
//  - POINT: 1 cycle, run 0, o_ball_reset=1.
//      If either score == WIN_SCORE -> OVER (o_winner set), else SERVE with counter reloaded.
//  - OVER:  run 0; scores and winner held; START ignored; only RESTART leaves (-> IDLE).
//  - Scores never exceed WIN_SCORE (saturate); no wrap at 2**SCORE_W.
//  - START held for many cycles: acted on once (the block leaves IDLE).
//    START in SERVE/PLAY/POINT is ignored.
//  - Reset mid-match (any state): same as power-up reset; no o_ball_reset pulse emitted.
// TESTING
//  1 Reset, key=103 -> state 1 next cycle, o_ball_reset 1 cycle.
//    60 frame ticks (SERVE_DELAY=60) -> state 2, o_ball_run=1.
//  2 PLAY, rise i_p1_scored and hold high 50 cycles -> p1_score=1 only.
//    Then 1 cycle POINT with o_ball_reset=1, serve_dir=0, then SERVE.
//  3 PLAY, both scored rise same cycle -> scores unchanged, POINT then SERVE, serve_dir kept.
//  4 P2 scores 7 times (WIN_SCORE=7) -> state 4, o_winner=2, p2_score=7.
//    Then key=103 -> stays OVER; key=98 -> IDLE, scores 0, winner 0.
//  5 Mid-PLAY at 3:2, key=98 with simultaneous p1 edge -> IDLE, scores 0, no increment.
//    Separately, i_RST_N=0 mid-SERVE -> all outputs 0 next cycle.
//  6 SERVE_DELAY=0 build -> SERVE lasts exactly 1 cycle.
//    Tick-free SERVE with SERVE_DELAY=60 -> stays SERVE indefinitely.

Source files
------------

// File: rtl/game_controller.sv
// Pong match sequencer: tracks scores from the ball stage's scored flags, paces
// serves off the frame tick and runs the IDLE/SERVE/PLAY/POINT/OVER match flow.
module game_controller #(
    parameter logic [7:0] START       = 8'd103,
    parameter logic [7:0] RESTART     = 8'd98,
    parameter int         WIN_SCORE   = 7,
    parameter int         SERVE_DELAY = 60,
    parameter int         SCORE_W     = 4
) (
    input  logic               i_CLK,
    input  logic               i_RST_N,
    input  logic               i_frame_tick,
    input  logic [7:0]         i_key_byte,
    input  logic               i_p1_scored,
    input  logic               i_p2_scored,
    output logic [2:0]         o_state,
    output logic               o_ball_run,
    output logic               o_ball_reset,
    output logic               o_serve_dir,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic [1:0]         o_winner
);

    localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               p1_prev_q, p2_prev_q;
    logic               run_q, run_d;
    logic               bres_q, bres_d;
    logic               dir_q, dir_d;
    logic [SCORE_W-1:0] p1s_q, p1s_d;
    logic [SCORE_W-1:0] p2s_q, p2s_d;
    logic [1:0]         win_q, win_d;
    logic               p1_edge, p2_edge;

    // Flags from the ball stage are levels; only their rising edge is a point.
    assign p1_edge = i_p1_scored & ~p1_prev_q;
    assign p2_edge = i_p2_scored & ~p2_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = 1'b0;
        bres_d  = 1'b0;
        dir_d   = dir_q;
        p1s_d   = p1s_q;
        p2s_d   = p2s_q;
        win_d   = win_q;

        if (i_key_byte == RESTART) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bres_d  = 1'b1;
            dir_d   = 1'b0;
            p1s_d   = '0;
            p2s_d   = '0;
            win_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_key_byte == START) begin
                        state_d = S_SERVE;
                        cnt_d   = CNT_LOAD;
                        bres_d  = 1'b1;
                        dir_d   = 1'b0;
                    end
                end
                S_SERVE: begin
                    if (cnt_q == '0) begin
                        state_d = S_PLAY;
                        run_d   = 1'b1;
                    end else if (i_frame_tick) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_PLAY: begin
                    run_d = 1'b1;
                    if (p1_edge || p2_edge) begin
                        state_d = S_POINT;
                        run_d   = 1'b0;
                        bres_d  = 1'b1;
                        // A simultaneous double edge is a replay: no score, no serve change.
                        if (p1_edge && !p2_edge) begin
                            dir_d = 1'b0;
                            if (p1s_q < WIN) p1s_d = p1s_q + 1'b1;
                        end else if (p2_edge && !p1_edge) begin
                            dir_d = 1'b1;
                            if (p2s_q < WIN) p2s_d = p2s_q + 1'b1;
                        end
                    end
                end
                S_POINT: begin
                    if (p1s_q == WIN || p2s_q == WIN) begin
                        state_d = S_OVER;
                        win_d   = (p1s_q == WIN) ? 2'd1 : 2'd2;
                    end else begin
                        state_d = S_SERVE;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            p1_prev_q <= 1'b0;
            p2_prev_q <= 1'b0;
            run_q     <= 1'b0;
            bres_q    <= 1'b0;
            dir_q     <= 1'b0;
            p1s_q     <= '0;
            p2s_q     <= '0;
            win_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p1_prev_q <= i_p1_scored;
            p2_prev_q <= i_p2_scored;
            run_q     <= run_d;
            bres_q    <= bres_d;
            dir_q     <= dir_d;
            p1s_q     <= p1s_d;
            p2s_q     <= p2s_d;
            win_q     <= win_d;
        end
    end

    assign o_state      = state_q;
    assign o_ball_run   = run_q;
    assign o_ball_reset = bres_q;
    assign o_serve_dir  = dir_q;
    assign o_p1_score   = p1s_q;
    assign o_p2_score   = p2s_q;
    assign o_winner     = win_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: default build plus a zero-delay serve build.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst_n, tick, p1, p2, p1_0, p2_0;
    logic [7:0] key, key0;

    logic [2:0] state, state0;
    logic       run, bres, dir, run0, bres0, dir0;
    logic [3:0] p1s, p2s, p1s0, p2s0;
    logic [1:0] win, win0;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    game_controller dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_frame_tick(tick), .i_key_byte(key),
        .i_p1_scored(p1), .i_p2_scored(p2),
        .o_state(state), .o_ball_run(run), .o_ball_reset(bres), .o_serve_dir(dir),
        .o_p1_score(p1s), .o_p2_score(p2s), .o_winner(win)
    );

    game_controller #(.SERVE_DELAY(0)) dut0 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_frame_tick(tick), .i_key_byte(key0),
        .i_p1_scored(p1_0), .i_p2_scored(p2_0),
        .o_state(state0), .o_ball_run(run0), .o_ball_reset(bres0), .o_serve_dir(dir0),
        .o_p1_score(p1s0), .o_p2_score(p2s0), .o_winner(win0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: observed=%0d expected=<nothing queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
            end
        end
    endtask

    task automatic serve_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    // Score one point from PLAY and ride the following serve back into PLAY.
    task automatic score_and_resume(input bit by_p2);
        if (by_p2) p2 = 1'b1;
        else       p1 = 1'b1;
        step();
        p1 = 1'b0;
        p2 = 1'b0;
        step();
        serve_ticks(60);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; key = 8'd0; key0 = 8'd0;
        p1 = 1'b0; p2 = 1'b0; p1_0 = 1'b0; p2_0 = 1'b0;
        push(0); push(0); push(0); push(0); push(0); push(0); push(0); push(0);
        step();
        step();
        check("rst_state", state);
        check("rst_run", run);
        check("rst_bres", bres);
        check("rst_dir", dir);
        check("rst_p1s", p1s);
        check("rst_p2s", p2s);
        check("rst_win", win);
        check("rst_state0", state0);
        rst_n = 1'b1;
        step();

        // Zero-delay serve build: SERVE lasts one cycle, also after a point.
        key0 = 8'd103;
        push(1); step(); check("d0_serve", state0);
        key0 = 8'd0;
        push(2); push(1); step(); check("d0_play", state0); check("d0_run", run0);
        p1_0 = 1'b1;
        push(3); step(); check("d0_point", state0);
        p1_0 = 1'b0;
        push(1); step(); check("d0_reserve", state0);
        push(2); push(1); step(); check("d0_replay", state0); check("d0_p1s", p1s0);

        // Start, held START acted on once, 60-tick serve.
        key = 8'd103;
        push(1); push(1); step(); check("t1_state", state); check("t1_bres", bres);
        push(1); push(0); step(); check("t1_state_held", state); check("t1_bres_pulse", bres);
        key = 8'd0;
        serve_ticks(59);
        push(1); check("t1_serve59", state);
        tick = 1'b1;
        push(1); step(); check("t1_cnt_zero", state);
        tick = 1'b0;
        push(2); push(1); step(); check("t1_play", state); check("t1_run", run);

        // P1 flag held high scores once.
        p1 = 1'b1;
        push(3); push(1); push(1); push(0); push(0); push(0);
        step();
        check("t2_point", state); check("t2_p1s", p1s); check("t2_bres", bres);
        check("t2_run", run); check("t2_dir", dir); check("t2_p2s", p2s);
        push(1); push(0); step(); check("t2_serve", state); check("t2_bres_off", bres);
        repeat (48) step();
        push(1); check("t2_p1s_held", p1s);
        serve_ticks(60);
        repeat (3) step();
        push(2); push(1); check("t2_play_held", state); check("t2_p1s_no_rescore", p1s);
        p1 = 1'b0;
        step();

        // Double edge is a replay.
        p1 = 1'b1; p2 = 1'b1;
        push(3); push(1); push(0); push(0);
        step();
        check("t3_point", state); check("t3_p1s", p1s); check("t3_p2s", p2s); check("t3_dir", dir);
        p1 = 1'b0; p2 = 1'b0;
        push(1); step(); check("t3_serve", state);
        serve_ticks(60);
        push(2); check("t3_play", state);

        // P2 takes seven points and the match.
        for (int k = 1; k <= 7; k++) begin
            p2 = 1'b1;
            push(3); push(8'(k)); push(1);
            step();
            check("t4_point", state); check("t4_p2s", p2s); check("t4_dir", dir);
            p2 = 1'b0;
            if (k < 7) begin
                push(1); step(); check("t4_serve", state);
                serve_ticks(60);
                push(2); check("t4_play", state);
            end else begin
                push(4); push(2); push(7); push(1); push(0);
                step();
                check("t4_over", state); check("t4_win", win); check("t4_p2s_final", p2s);
                check("t4_p1s_final", p1s); check("t4_run", run);
            end
        end
        key = 8'd103;
        push(4); step(); check("t4_start_ignored", state);
        push(4); push(2); step(); check("t4_still_over", state); check("t4_win_held", win);
        key = 8'd98;
        push(0); push(0); push(0); push(0); push(1);
        step();
        check("t4_idle", state); check("t4_p1s_clr", p1s); check("t4_p2s_clr", p2s);
        check("t4_win_clr", win); check("t4_bres", bres);
        key = 8'd0;
        step();

        // Restart at 3:2 beats a same-cycle P1 edge.
        key = 8'd103; step(); key = 8'd0;
        serve_ticks(60);
        score_and_resume(1'b0);
        score_and_resume(1'b0);
        score_and_resume(1'b0);
        score_and_resume(1'b1);
        score_and_resume(1'b1);
        push(2); push(3); push(2); push(1);
        check("t5_play", state); check("t5_p1s", p1s); check("t5_p2s", p2s); check("t5_dir", dir);
        key = 8'd98; p1 = 1'b1;
        push(0); push(0); push(0); push(1);
        step();
        check("t5_idle", state); check("t5_p1s", p1s); check("t5_p2s", p2s); check("t5_bres", bres);
        key = 8'd0; p1 = 1'b0;
        step();

        // Reset mid-SERVE with a nonzero score and serve_dir set.
        key = 8'd103; step(); key = 8'd0;
        serve_ticks(60);
        p2 = 1'b1; step(); p2 = 1'b0; step();
        push(1); push(1); push(1);
        check("t5b_serve", state); check("t5b_p2s", p2s); check("t5b_dir", dir);
        serve_ticks(5);
        rst_n = 1'b0;
        push(0); push(0); push(0); push(0); push(0); push(0); push(0);
        step();
        check("t5b_state", state); check("t5b_run", run); check("t5b_bres", bres);
        check("t5b_dir_rst", dir); check("t5b_p1s", p1s); check("t5b_p2s_rst", p2s); check("t5b_win", win);
        rst_n = 1'b1;
        step();

        // Without frame ticks SERVE never ends.
        key = 8'd103; step(); key = 8'd0;
        repeat (200) step();
        push(1); push(0); check("t6_stuck_serve", state); check("t6_run", run);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_expectations: observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
